// File: rtl/ioctl_host.sv
// Byte-stream bridge that drives a core-side ioctl port: downloads bytes from a
// source into the core, or uploads bytes from the core into a sink.
module ioctl_host #(
  parameter int WR_GAP = 3,
  parameter int UL_LAT = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cmd_dl,
  input  logic        cmd_ul,
  input  logic [7:0]  cmd_index,
  input  logic [24:0] cmd_len,
  output logic        busy,
  output logic        done,
  output logic        src_rd,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic [7:0]  snk_data,
  output logic        snk_wr,
  output logic        ioctl_download,
  output logic        ioctl_upload,
  output logic        ioctl_wr,
  output logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_dout,
  output logic [7:0]  ioctl_index,
  input  logic [7:0]  ioctl_din,
  input  logic        ioctl_wait
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FETCH, S_WRITE, S_GAP, S_SAMPLE, S_FINISH
  } state_t;

  // The wr cycle counts as the first of the WR_GAP idle-count cycles, so GAP
  // itself only has to cover WR_GAP-1 of them.
  localparam logic [4:0] GAP_LAST = 5'(WR_GAP - 1);
  localparam logic [4:0] LAT_C    = 5'(UL_LAT);

  state_t      state_q, state_d;
  logic        ul_q, ul_d;
  logic        first_q, first_d;
  logic [24:0] cnt_q, cnt_d;
  logic [24:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  snk_data_q, snk_data_d;
  logic [4:0]  since_q, since_d;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ul_q       <= 1'b0;
      first_q    <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      dout_q     <= '0;
      index_q    <= '0;
      snk_data_q <= '0;
      since_q    <= '0;
    end else begin
      state_q    <= state_d;
      ul_q       <= ul_d;
      first_q    <= first_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      index_q    <= index_d;
      snk_data_q <= snk_data_d;
      since_q    <= since_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ul_d       = ul_q;
    first_d    = first_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    index_d    = index_q;
    snk_data_d = snk_data_q;
    since_d    = since_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_dl || cmd_ul) begin
          ul_d    = ~cmd_dl;
          index_d = cmd_index;
          cnt_d   = cmd_len;
          addr_d  = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == 25'd0) begin
          state_d = S_FINISH;
        end else if (ul_q) begin
          state_d = S_WRITE;
        end else begin
          first_d = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        first_d = 1'b0;
        if (!first_q && src_valid) begin
          dout_d  = src_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!ioctl_wait) begin
          cnt_d   = cnt_q - 25'd1;
          since_d = 5'd1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (since_q != 5'd31) since_d = since_q + 5'd1;
        // Core data is valid exactly UL_LAT cycles after the wr pulse.
        if (ul_q && since_q == LAT_C) snk_data_d = ioctl_din;
        if (since_q >= GAP_LAST && !ioctl_wait && (!ul_q || since_q >= LAT_C)) begin
          if (ul_q) begin
            state_d = S_SAMPLE;
          end else if (cnt_q == 25'd0) begin
            state_d = S_FINISH;
          end else begin
            addr_d  = addr_q + 25'd1;
            first_d = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_SAMPLE: begin
        if (cnt_q == 25'd0) begin
          state_d = S_FINISH;
        end else begin
          addr_d  = addr_q + 25'd1;
          state_d = S_WRITE;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_FINISH);
  assign src_rd         = (state_q == S_FETCH) && first_q;
  assign snk_wr         = (state_q == S_SAMPLE);
  assign snk_data       = snk_data_q;
  assign ioctl_download = busy && !ul_q;
  assign ioctl_upload   = busy && ul_q;
  // Gated so a wait raised during the write cycle suppresses the pulse.
  assign ioctl_wr       = (state_q == S_WRITE) && !ioctl_wait;
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;
  assign ioctl_index    = index_q;

endmodule

// File: doc/ioctl_host.md
IOCTL_HOST -- requirements
Module: ioctl_host

Interface
REQ-001 SHALL have parameter WR_GAP, default 3: minimum idle cycles after each ioctl_wr pulse, range 1..15.
REQ-002 SHALL have parameter UL_LAT, default 2: cycles from an upload ioctl_wr pulse to the ioctl_din sample, range 1..7.
REQ-003 SHALL have one clock and an asynchronous active-high reset:
- clk_sys  in  1  sole clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high.
REQ-004 SHALL have these command ports:
- cmd_dl  in  1  download start, one-cycle pulse.
- cmd_ul  in  1  upload start, one-cycle pulse.
- cmd_index  in  8  transfer index.
- cmd_len  in  25  byte count; 0 is legal.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
REQ-005 SHALL have these byte source and sink ports:
- src_rd  out  1  one-cycle request for the next download byte.
- src_data  in  8  download byte.
- src_valid  in  1  src_data valid.
- snk_data  out  8  uploaded byte.
- snk_wr  out  1  snk_data valid, one cycle.
REQ-006 SHALL have these ioctl ports, driving the core-side ioctl port:
- ioctl_download  out  1
- ioctl_upload  out  1
- ioctl_wr  out  1
- ioctl_addr  out  25
- ioctl_dout  out  8
- ioctl_index  out  8
- ioctl_din  in  8
- ioctl_wait  in  1

Function
REQ-007 SHALL implement the states IDLE, SETUP, FETCH, WRITE, GAP, SAMPLE and FINISH.
REQ-008 In IDLE, a sampled cmd_dl or cmd_ul SHALL:
- latch cmd_index into ioctl_index and cmd_len into an internal counter;
- clear ioctl_addr;
- go to SETUP.
- If both are high, cmd_dl SHALL win.
REQ-009 cmd_dl and cmd_ul SHALL be ignored in every state other than IDLE.
REQ-010 SETUP SHALL last 1 cycle, with ioctl_download (download) or ioctl_upload (upload) high from SETUP through FINISH inclusive.
REQ-011 From SETUP:
- remaining count 0 -> FINISH;
- download -> FETCH;
- upload -> WRITE.
REQ-012 FETCH SHALL assert src_rd on its first cycle only.
- Leaves FETCH on the first following cycle with src_valid=1, latching src_data into ioctl_dout, then goes to WRITE.
- src_valid in the src_rd cycle SHALL be ignored.
REQ-013 WRITE SHALL:
- assert ioctl_wr for exactly 1 cycle, with ioctl_addr and ioctl_dout stable in that cycle;
- decrement the remaining count;
- go to GAP.
REQ-014 GAP SHALL count WR_GAP cycles.
- Leaves GAP only when the count has expired and ioctl_wait=0.
- ioctl_wait=1 SHALL hold GAP indefinitely.
- Upload -> SAMPLE once UL_LAT is also satisfied.
- Download: remaining 0 -> FINISH, else -> FETCH, with ioctl_addr+1.
REQ-015 SAMPLE SHALL:
- capture ioctl_din into snk_data exactly UL_LAT cycles after the ioctl_wr cycle;
- pulse snk_wr;
- then go to FINISH if remaining is 0, else to WRITE with ioctl_addr+1.
REQ-016 FINISH SHALL last 1 cycle and pulse done.
- ioctl_download and ioctl_upload fall on the next cycle.
- ioctl_addr and ioctl_dout retain their last values.
- Next state is IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 ioctl_addr SHALL increment by exactly 1 per byte, from 0 to cmd_len-1.
- A 25-bit wrap is impossible by construction.
REQ-019 At most one ioctl_wr pulse SHALL occur per byte.
- Consecutive pulses SHALL be at least WR_GAP+1 cycles apart.
REQ-020 ioctl_wr SHALL never be asserted while ioctl_wait=1.

Reset
REQ-021 On reset assertion, all state SHALL clear immediately, even mid-transfer: state IDLE, all outputs 0.
- No done pulse.
REQ-022 After reset release, the first command SHALL be accepted on the first rising clk_sys edge.

Verification
REQ-023 A bench SHALL cover these scenarios:
- Download: cmd_dl, index 0x00, len 4, bytes A0..A3, src_valid 1 cycle after src_rd, ioctl_wait=0 -> 4 ioctl_wr pulses at addr 0..3 with dout A0..A3, pulses 5 cycles apart, exactly one done.
- Upload: cmd_ul, len 3, ioctl_din = 0x10+addr valid 2 cycles after ioctl_wr -> snk_data 0x10, 0x11, 0x12, 3 snk_wr pulses, ioctl_upload high throughout, done once.
- Zero length: cmd_dl, len 0 -> ioctl_download high for 2 cycles, no ioctl_wr, no src_rd, done once.
- Wait stall: ioctl_wait high for 20 cycles after the second byte of a len 4 download -> no ioctl_wr during the stall, third ioctl_wr at addr 2 in the first legal cycle after wait falls.
- Mid-transfer reset: reset at byte 2 of len 8 -> immediate return to IDLE, all outputs 0, no done; a new cmd_ul len 1 then completes normally.
- Simultaneous and ignored commands: cmd_dl and cmd_ul in the same cycle -> download only; cmd_ul while busy -> ignored, only one done.
